// File: rtl/sr_trigger_conditioner_if.sv
// Signal bundle between the SR trigger conditioner and its sample source / ignition controller.
// The master side drives the sample strobe, inputs and thresholds; the slave side returns the qualifiers.
interface sr_trigger_conditioner_if #(
   parameter int WIDTH = 18
);
   logic                    clk_en;
   logic signed [WIDTH-1:0] cos_dphi;
   logic signed [WIDTH-1:0] beta_amp;
   logic signed [WIDTH-1:0] beta_lo_thr;
   logic signed [WIDTH-1:0] beta_hi_thr;
   logic [15:0]             quiet_dwell;
   logic signed [WIDTH-1:0] coherence_out;
   logic                    beta_quiet;
   logic                    warmup_done;

   modport master (
      output clk_en, cos_dphi, beta_amp, beta_lo_thr, beta_hi_thr, quiet_dwell,
      input  coherence_out, beta_quiet, warmup_done
   );

   modport slave (
      input  clk_en, cos_dphi, beta_amp, beta_lo_thr, beta_hi_thr, quiet_dwell,
      output coherence_out, beta_quiet, warmup_done
   );
endinterface

// File: rtl/sr_trigger_conditioner.sv
// Conditions phase agreement into a clamped Q14 EMA coherence estimate and beta amplitude into a
// debounced, hysteretic quiet flag; all state advances on the sample strobe only.
module sr_trigger_conditioner #(
   parameter int WIDTH       = 18,
   parameter int FRAC        = 14,
   parameter int ALPHA_SHIFT = 6,
   parameter int WARMUP      = 256
) (
   input  logic                    clk,
   input  logic                    rst_n,
   sr_trigger_conditioner_if.slave sif
);
   localparam int ACC_W = WIDTH + ALPHA_SHIFT + 1;
   localparam int WC_W  = $clog2(WARMUP + 1);
   localparam logic signed [WIDTH-1:0] ONE = WIDTH'(2 ** FRAC);

   typedef enum logic [1:0] {NOISY, ARMING, QUIET} state_t;

   function automatic logic signed [WIDTH-1:0] clamp_unit(input logic signed [ACC_W-1:0] v);
      if (v < 0)
         return '0;
      if (v > ONE)
         return ONE;
      return v[WIDTH-1:0];
   endfunction

   logic signed [ACC_W-1:0] acc_p0;
   logic signed [ACC_W-1:0] cos_ext;
   logic signed [ACC_W-1:0] acc_nxt;
   logic signed [ACC_W-1:0] est_nxt;
   logic signed [WIDTH-1:0] coh_p0;
   logic [WC_W-1:0]         wcnt;
   logic [WC_W-1:0]         wcnt_nxt;
   logic                    done_p0;
   logic                    done_nxt;

   assign cos_ext  = {{(ACC_W-WIDTH){sif.cos_dphi[WIDTH-1]}}, sif.cos_dphi};
   assign acc_nxt  = acc_p0 + cos_ext - (acc_p0 >>> ALPHA_SHIFT);
   assign est_nxt  = acc_nxt >>> ALPHA_SHIFT;
   assign wcnt_nxt = (wcnt == WC_W'(WARMUP)) ? wcnt : wcnt + 1'b1;
   assign done_nxt = done_p0 | (wcnt_nxt == WC_W'(WARMUP));

   // Sample stage: EMA update and warm-up counter; the output reflects the sample just taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_p0  <= '0;
         wcnt    <= '0;
         done_p0 <= 1'b0;
         coh_p0  <= '0;
      end else if (sif.clk_en) begin
         acc_p0  <= acc_nxt;
         wcnt    <= wcnt_nxt;
         done_p0 <= done_nxt;
         coh_p0  <= done_nxt ? clamp_unit(est_nxt) : '0;
      end
   end

   assign sif.coherence_out = coh_p0;
   assign sif.warmup_done   = done_p0;

   state_t                  state_q;
   state_t                  state_d;
   logic [15:0]             dcnt_q;
   logic [15:0]             dcnt_d;
   logic [15:0]             dwell_eff;
   logic [16:0]             dcnt_inc;
   logic signed [WIDTH-1:0] hi_eff;

   assign dwell_eff = (sif.quiet_dwell == 16'd0) ? 16'd1 : sif.quiet_dwell;
   assign hi_eff    = (sif.beta_hi_thr > sif.beta_lo_thr) ? sif.beta_hi_thr : sif.beta_lo_thr;
   assign dcnt_inc  = {1'b0, dcnt_q} + 17'd1;

   // A dwell lowered below the running count releases to QUIET on the next below-lo sample.
   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      case (state_q)
         NOISY: begin
            if (sif.beta_amp < sif.beta_lo_thr) begin
               dcnt_d  = 16'd1;
               state_d = (dwell_eff == 16'd1) ? QUIET : ARMING;
            end
         end
         ARMING: begin
            if (sif.beta_amp >= sif.beta_lo_thr) begin
               dcnt_d  = '0;
               state_d = NOISY;
            end else begin
               dcnt_d = dcnt_inc[15:0];
               if (dcnt_inc >= {1'b0, dwell_eff})
                  state_d = QUIET;
            end
         end
         QUIET: begin
            if (sif.beta_amp > hi_eff) begin
               dcnt_d  = '0;
               state_d = NOISY;
            end
         end
         default: begin
            dcnt_d  = '0;
            state_d = NOISY;
         end
      endcase
   end

   // Quiet FSM stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= NOISY;
         dcnt_q  <= '0;
      end else if (sif.clk_en) begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
      end
   end

   assign sif.beta_quiet = (state_q == QUIET);
endmodule
